match_stream_gen: RTL

- Drives the serial match stream (valid, match_bit) consumed by the alignment match counter.
- Fetches target and reference base symbols from two synchronous-read memories and compares them one symbol at a time.
- Each matching symbol is framed as exactly 3 consecutive match_bit=1 beats; the first mismatch drops the attempt.
- Slides the reference offset by one after each failed attempt and reports the first full-match position.

---
 rtl/match_stream_gen_pkg.sv | 31 +++
 rtl/match_stream_gen_if.sv | 33 +++
 rtl/match_stream_gen_sym_prefetch.sv | 54 +++++
 rtl/match_stream_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/match_stream_gen_pkg.sv
// Shared definitions for the match stream generator and its match counter receiver:
// base encodings, stream framing constants, default memory geometry and the FSM states.
package match_stream_gen_pkg;

  localparam int SYM_W = 2;
  localparam int BEATS = 3;

  localparam int TAGT_NUM_DEF    = 64;
  localparam int TAGT_LENGTH_DEF = 6;
  localparam int REF_NUM_DEF     = 1024;
  localparam int REF_LENGTH_DEF  = 10;

  localparam logic [SYM_W-1:0] BASE_A = 2'd0;
  localparam logic [SYM_W-1:0] BASE_C = 2'd1;
  localparam logic [SYM_W-1:0] BASE_G = 2'd2;
  localparam logic [SYM_W-1:0] BASE_T = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD0 = 3'd1,
    ST_LOAD1 = 3'd2,
    ST_EMIT  = 3'd3,
    ST_TAIL  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic logic sym_match(input logic [SYM_W-1:0] a, input logic [SYM_W-1:0] b);
    return (a == b);
  endfunction

endpackage

// File: rtl/match_stream_gen_if.sv
// Control, memory read and match stream signals of the match stream generator.
// master = generator side, slave = host / memories / receiver side.
interface match_stream_gen_if
  import match_stream_gen_pkg::*;
#(
  parameter int TAGT_LENGTH = TAGT_LENGTH_DEF,
  parameter int REF_LENGTH  = REF_LENGTH_DEF
) ();

  logic                   start;
  logic [REF_LENGTH-1:0]  start_off;
  logic [TAGT_LENGTH-1:0] tgt_addr;
  logic [SYM_W-1:0]       tgt_sym;
  logic [REF_LENGTH-1:0]  ref_addr;
  logic [SYM_W-1:0]       ref_sym;
  logic                   valid;
  logic                   match_bit;
  logic                   busy;
  logic                   done;
  logic                   hit;
  logic [REF_LENGTH-1:0]  match_pos;

  modport master (
    input  start, start_off, tgt_sym, ref_sym,
    output tgt_addr, ref_addr, valid, match_bit, busy, done, hit, match_pos
  );

  modport slave (
    output start, start_off, tgt_sym, ref_sym,
    input  tgt_addr, ref_addr, valid, match_bit, busy, done, hit, match_pos
  );

endinterface

// File: rtl/match_stream_gen_sym_prefetch.sv
// Address generation and symbol compare for the match stream generator: registered
// read addresses, one-cycle read latency, current (eq) and prefetched (eq_next) results.
module match_stream_gen_sym_prefetch
  import match_stream_gen_pkg::*;
#(
  parameter int TAGT_LENGTH = TAGT_LENGTH_DEF,
  parameter int REF_LENGTH  = REF_LENGTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   addr_ld,
  input  logic [REF_LENGTH-1:0]  base,
  input  logic [TAGT_LENGTH:0]   idx,
  input  logic                   eq_ld,
  input  logic                   eq_next_ld,
  input  logic                   eq_shift,
  input  logic [SYM_W-1:0]       tgt_sym,
  input  logic [SYM_W-1:0]       ref_sym,
  output logic [TAGT_LENGTH-1:0] tgt_addr,
  output logic [REF_LENGTH-1:0]  ref_addr,
  output logic                   sym_eq,
  output logic                   eq,
  output logic                   eq_next
);

  logic [REF_LENGTH-1:0] idx_ext_s;

  assign sym_eq    = sym_match(tgt_sym, ref_sym);
  assign idx_ext_s = REF_LENGTH'(idx);

  // Address registers and compare-result registers; the sum wraps at the address width
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_addr <= '0;
      ref_addr <= '0;
      eq       <= 1'b0;
      eq_next  <= 1'b0;
    end else begin
      if (addr_ld) begin
        tgt_addr <= idx[TAGT_LENGTH-1:0];
        ref_addr <= base + idx_ext_s;
      end
      if (eq_ld) begin
        eq <= sym_eq;
      end else if (eq_shift) begin
        eq <= eq_next;
      end
      if (eq_next_ld) begin
        eq_next <= sym_eq;
      end
    end
  end

endmodule

// File: rtl/match_stream_gen.sv
// Match stream generator: slides the reference offset, frames each matching symbol as
// BEATS ones and reports the first full match. `define REF_WRAP_EN for a circular reference.
module match_stream_gen
  import match_stream_gen_pkg::*;
#(
  parameter int TAGT_NUM    = TAGT_NUM_DEF,
  parameter int TAGT_LENGTH = TAGT_LENGTH_DEF,
  parameter int REF_NUM     = REF_NUM_DEF,
  parameter int REF_LENGTH  = REF_LENGTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  match_stream_gen_if.master bus
);

  // One spare offset bit so a wrapped reference can still step past its last offset
  localparam int OFF_W = REF_LENGTH + 1;
  localparam int IDX_W = TAGT_LENGTH + 1;
`ifdef REF_WRAP_EN
  localparam logic [OFF_W-1:0] LIMIT = OFF_W'(REF_NUM - 1);
`else
  localparam logic [OFF_W-1:0] LIMIT = OFF_W'(REF_NUM - TAGT_NUM);
`endif
  localparam logic [TAGT_LENGTH-1:0] J_LAST = TAGT_LENGTH'(TAGT_NUM - 1);
  localparam logic [1:0]             B_LAST = 2'(BEATS - 1);

  state_t                 state_r, state_n_s;
  logic [OFF_W-1:0]       offset_r, offset_n_s;
  logic [TAGT_LENGTH-1:0] j_r, j_n_s;
  logic [1:0]             b_r, b_n_s;
  logic                   valid_r, valid_n_s;
  logic                   match_bit_r, match_bit_n_s;
  logic                   busy_r, busy_n_s;
  logic                   done_r, done_n_s;
  logic                   hit_r, hit_n_s;
  logic [REF_LENGTH-1:0]  match_pos_r, match_pos_n_s;

  logic                   addr_ld_s, eq_ld_s, eq_next_ld_s, eq_shift_s;
  logic [REF_LENGTH-1:0]  base_s;
  logic [IDX_W-1:0]       idx_s;
  logic                   sym_eq_s, eq_s, eq_next_s;
  logic [TAGT_LENGTH-1:0] tgt_addr_s;
  logic [REF_LENGTH-1:0]  ref_addr_s;

  match_stream_gen_sym_prefetch #(
    .TAGT_LENGTH (TAGT_LENGTH),
    .REF_LENGTH  (REF_LENGTH)
  ) u_prefetch (
    .clk        (clk),
    .rst        (rst),
    .addr_ld    (addr_ld_s),
    .base       (base_s),
    .idx        (idx_s),
    .eq_ld      (eq_ld_s),
    .eq_next_ld (eq_next_ld_s),
    .eq_shift   (eq_shift_s),
    .tgt_sym    (bus.tgt_sym),
    .ref_sym    (bus.ref_sym),
    .tgt_addr   (tgt_addr_s),
    .ref_addr   (ref_addr_s),
    .sym_eq     (sym_eq_s),
    .eq         (eq_s),
    .eq_next    (eq_next_s)
  );

  // Next state, next registered outputs and prefetch controls
  always_comb begin
    state_n_s     = state_r;
    offset_n_s    = offset_r;
    j_n_s         = j_r;
    b_n_s         = b_r;
    valid_n_s     = 1'b0;
    match_bit_n_s = 1'b0;
    busy_n_s      = busy_r;
    done_n_s      = done_r;
    hit_n_s       = hit_r;
    match_pos_n_s = match_pos_r;
    addr_ld_s     = 1'b0;
    idx_s         = '0;
    eq_ld_s       = 1'b0;
    eq_next_ld_s  = 1'b0;
    eq_shift_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_n_s  = ST_LOAD0;
          offset_n_s = {1'b0, bus.start_off};
          busy_n_s   = 1'b1;
          done_n_s   = 1'b0;
          hit_n_s    = 1'b0;
          addr_ld_s  = 1'b1;
        end else begin
          valid_n_s  = hit_r;
        end
      end
      ST_LOAD0: begin
        if (offset_r > LIMIT) begin
          state_n_s = ST_DONE;
          busy_n_s  = 1'b0;
          done_n_s  = 1'b1;
        end else begin
          state_n_s = ST_LOAD1;
        end
      end
      ST_LOAD1: begin
        state_n_s     = ST_EMIT;
        j_n_s         = '0;
        b_n_s         = 2'd0;
        eq_ld_s       = 1'b1;
        valid_n_s     = 1'b1;
        match_bit_n_s = sym_eq_s;
        addr_ld_s     = 1'b1;
        idx_s         = IDX_W'(1);
      end
      ST_EMIT: begin
        if ((b_r == 2'd0) && !eq_s) begin
          state_n_s  = ST_LOAD0;
          offset_n_s = offset_r + OFF_W'(1);
          addr_ld_s  = 1'b1;
        end else if (b_r != B_LAST) begin
          b_n_s         = b_r + 2'd1;
          valid_n_s     = 1'b1;
          match_bit_n_s = eq_s;
          eq_next_ld_s  = (b_r == 2'd1);
        end else if (j_r != J_LAST) begin
          j_n_s         = j_r + TAGT_LENGTH'(1);
          b_n_s         = 2'd0;
          valid_n_s     = 1'b1;
          match_bit_n_s = eq_next_s;
          eq_shift_s    = 1'b1;
          addr_ld_s     = 1'b1;
          idx_s         = {1'b0, j_r} + IDX_W'(2);
        end else begin
          state_n_s     = ST_TAIL;
          valid_n_s     = 1'b1;
        end
      end
      ST_TAIL: begin
        state_n_s     = ST_DONE;
        valid_n_s     = 1'b1;
        busy_n_s      = 1'b0;
        done_n_s      = 1'b1;
        hit_n_s       = 1'b1;
        match_pos_n_s = offset_r[REF_LENGTH-1:0];
      end
      default: begin
        state_n_s = ST_IDLE;
        busy_n_s  = 1'b0;
        done_n_s  = 1'b0;
        hit_n_s   = 1'b0;
      end
    endcase
    base_s = offset_n_s[REF_LENGTH-1:0];
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      offset_r    <= '0;
      j_r         <= '0;
      b_r         <= 2'd0;
      valid_r     <= 1'b0;
      match_bit_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      hit_r       <= 1'b0;
      match_pos_r <= '0;
    end else begin
      state_r     <= state_n_s;
      offset_r    <= offset_n_s;
      j_r         <= j_n_s;
      b_r         <= b_n_s;
      valid_r     <= valid_n_s;
      match_bit_r <= match_bit_n_s;
      busy_r      <= busy_n_s;
      done_r      <= done_n_s;
      hit_r       <= hit_n_s;
      match_pos_r <= match_pos_n_s;
    end
  end

  assign bus.tgt_addr  = tgt_addr_s;
  assign bus.ref_addr  = ref_addr_s;
  assign bus.valid     = valid_r;
  assign bus.match_bit = match_bit_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.hit       = hit_r;
  assign bus.match_pos = match_pos_r;

endmodule
